// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, sizes.
// MDU_MULT_EN (define) enables the MULT datapath in mdu_step/mdu_ctrl.
package mdu_pkg;
  localparam int XLEN     = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT + 1);

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  // Operation context latched at accept and consumed by the sign fix-up.
  typedef struct packed {
    op_e  op;
    logic sa;
    logic sb;
  } op_ctx_t;

  // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the issue stage and mdu_ctrl.
interface mdu_if;
  logic                      op_valid;
  logic [1:0]                op_code;
  logic [mdu_pkg::XLEN-1:0]  a, b;
  logic                      abort;
  logic                      op_ready, busy;
  logic [mdu_pkg::XLEN-1:0]  hi, lo;
  logic                      done, div_zero, illegal_op;

  modport master (output op_valid, op_code, a, b, abort,
                  input  op_ready, busy, hi, lo, done, div_zero, illegal_op);
  modport slave  (input  op_valid, op_code, a, b, abort,
                  output op_ready, busy, hi, lo, done, div_zero, illegal_op);
endinterface

// File: rtl/mdu_step.sv
// One unsigned iteration: restoring divide step (left shift) or, with
// MDU_MULT_EN, a shift-add multiply step (right shift) on the {hi,lo} pair.
module mdu_step import mdu_pkg::*; (
`ifdef MDU_MULT_EN
  input  logic            is_mult,
`endif
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] mcand,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN-1:0] rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] div_hi, div_lo;

  // Partial remainder stays below the divisor, so a 33-bit difference
  // has its top bit set exactly when the trial subtraction underflows.
  assign rem_sh = {hi[XLEN-2:0], lo[XLEN-1]};
  assign diff   = {hi, lo[XLEN-1]} - {1'b0, mcand};
  assign ge     = ~diff[XLEN];
  assign div_hi = ge ? diff[XLEN-1:0] : rem_sh;
  assign div_lo = {lo[XLEN-2:0], ge};

`ifdef MDU_MULT_EN
  logic [XLEN:0] sum;
  assign sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {XLEN{1'b0}})};

  always_comb begin
    hi_n = div_hi;
    lo_n = div_lo;
    if (is_mult) begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end
`else
  assign hi_n = div_hi;
  assign lo_n = div_lo;
`endif
endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MDU control: IDLE/RUN/FIX FSM around mdu_step plus HI/LO registers.
// MULT is accepted as a real operation only when MDU_MULT_EN is defined.
module mdu_ctrl import mdu_pkg::*; (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  state_e          state, state_n;
  op_ctx_t         ctx;
  op_e             op;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hw, lw, mc, hw_n, lw_n;
  logic [XLEN-1:0] hi_q, lo_q, hi_fix, lo_fix;
  logic [2*XLEN-1:0] prod_s;
  logic            neg, start, wr_fix, wr_hi, wr_lo;
  logic            done_n, dz_n, ill_n;
  logic            done_q, dz_q, ill_q;

  assign op = op_e'(bus.op_code);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    wr_fix  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    done_n  = 1'b0;
    dz_n    = 1'b0;
    ill_n   = 1'b0;
    case (state)
      S_IDLE: if (bus.op_valid) begin
        case (op)
          OP_MTHI: begin wr_hi = 1'b1; done_n = 1'b1; end
          OP_MTLO: begin wr_lo = 1'b1; done_n = 1'b1; end
          OP_DIV:
            if (bus.b == '0) begin
              dz_n   = 1'b1;
              done_n = 1'b1;
            end else begin
              start   = 1'b1;
              state_n = S_RUN;
            end
          default: begin
`ifdef MDU_MULT_EN
            start   = 1'b1;
            state_n = S_RUN;
`else
            ill_n  = 1'b1;
            done_n = 1'b1;
`endif
          end
        endcase
      end
      S_RUN:
        if (bus.abort)               state_n = S_IDLE;
        else if (cnt == CNT_W'(1))   state_n = S_FIX;
      S_FIX: begin
        state_n = S_IDLE;
        if (!bus.abort) begin
          wr_fix = 1'b1;
          done_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  mdu_step u_step (
`ifdef MDU_MULT_EN
    .is_mult (ctx.op == OP_MULT),
`endif
    .hi      (hw),
    .lo      (lw),
    .mcand   (mc),
    .hi_n    (hw_n),
    .lo_n    (lw_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      hw  <= '0;
      lw  <= '0;
      mc  <= '0;
      ctx <= '0;
    end else if (start) begin
      cnt <= CNT_W'(ITER_CNT);
      hw  <= '0;
      lw  <= mag(bus.a);
      mc  <= mag(bus.b);
      ctx <= '{op: op, sa: bus.a[XLEN-1], sb: bus.b[XLEN-1]};
    end else if (state == S_RUN) begin
      if (bus.abort) begin
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
        hw  <= hw_n;
        lw  <= lw_n;
      end
    end
  end

  // Quotient sign follows the operand signs, remainder sign follows the dividend.
  assign neg    = ctx.sa ^ ctx.sb;
  assign prod_s = neg ? -{hw, lw} : {hw, lw};
  assign hi_fix = (ctx.op == OP_DIV) ? (ctx.sa ? -hw : hw) : prod_s[2*XLEN-1:XLEN];
  assign lo_fix = (ctx.op == OP_DIV) ? (neg ? -lw : lw)    : prod_s[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      done_q <= done_n;
      dz_q   <= dz_n;
      ill_q  <= ill_n;
      if (wr_fix) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end else begin
        if (wr_hi) hi_q <= bus.a;
        if (wr_lo) lo_q <= bus.a;
      end
    end
  end

  assign bus.op_ready   = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.done       = done_q;
  assign bus.div_zero   = dz_q;
  assign bus.illegal_op = ill_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: transaction-level reference model checked every
// cycle, plus hand-computed literal results and latency checks.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mdu_if bus();
  mdu_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: results from plain signed arithmetic, completion after a
  // fixed 33 edges past the accept edge, abort/reset cancel anything pending.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic        m_done, m_dz, m_ill;
  int          pend = 0;
  bit          started = 0;

  always @(posedge clk) begin
    longint la, lb, q, r;
    started = 1;
    m_done = 0; m_dz = 0; m_ill = 0;
    if (reset) begin
      m_hi = 0; m_lo = 0; pend = 0;
    end else if (pend > 0) begin
      if (bus.abort) pend = 0;
      else begin
        pend--;
        if (pend == 0) begin
          {m_hi, m_lo} = m_res;
          m_done = 1;
        end
      end
    end else if (bus.op_valid) begin
      la = longint'($signed(bus.a));
      lb = longint'($signed(bus.b));
      case (bus.op_code)
        2'b10: begin m_hi = bus.a; m_done = 1; end
        2'b11: begin m_lo = bus.a; m_done = 1; end
        2'b01:
          if (bus.b == 0) begin m_dz = 1; m_done = 1; end
          else begin
            q = la / lb;
            r = la % lb;
            m_res = {r[31:0], q[31:0]};
            pend = 33;
          end
        default: begin
`ifdef MDU_MULT_EN
          q = la * lb;
          m_res = q[63:0];
          pend = 33;
`else
          m_ill = 1; m_done = 1;
`endif
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("hi",         {32'b0, bus.hi},     {32'b0, m_hi});
      chk("lo",         {32'b0, bus.lo},     {32'b0, m_lo});
      chk("done",       {63'b0, bus.done},   {63'b0, m_done});
      chk("div_zero",   {63'b0, bus.div_zero},   {63'b0, m_dz});
      chk("illegal_op", {63'b0, bus.illegal_op}, {63'b0, m_ill});
      chk("op_ready",   {63'b0, bus.op_ready},   {63'b0, (pend == 0)});
      chk("busy",       {63'b0, bus.busy},       {63'b0, (pend != 0)});
    end
  end

  // Drive at a negedge, accept on the next posedge, return at the following
  // negedge (cycle 1 after accept).
  task automatic issue(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic ab = 1'b0);
    bus.op_valid = 1'b1; bus.op_code = op; bus.a = av; bus.b = bv; bus.abort = ab;
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n, seen;
  logic [31:0] exp_hi, exp_lo;

  initial begin
    reset = 1'b1;
    bus.op_valid = 1'b0; bus.op_code = 2'b00; bus.a = '0; bus.b = '0; bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi", {32'b0, bus.hi}, 64'h0);
    chk("rst_busy", {63'b0, bus.busy}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {63'b0, bus.op_ready}, 64'h1);

    issue(2'b01, 32'd7, 32'd2);
    wait_done(n);
    chk("div7_2_lat", 64'(n), 64'd34);
    chk("div7_2_lo", {32'b0, bus.lo}, 64'd3);
    chk("div7_2_hi", {32'b0, bus.hi}, 64'd1);

    issue(2'b01, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    chk("divm7_lo", {32'b0, bus.lo}, 64'hFFFFFFFD);
    chk("divm7_hi", {32'b0, bus.hi}, 64'hFFFFFFFF);

    issue(2'b01, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    chk("divovf_lo", {32'b0, bus.lo}, 64'h80000000);
    chk("divovf_hi", {32'b0, bus.hi}, 64'h0);

    issue(2'b10, 32'h11, 32'h0);
    chk("mthi_done", {63'b0, bus.done}, 64'h1);
    chk("mthi_hi", {32'b0, bus.hi}, 64'h11);
    issue(2'b11, 32'h22, 32'h0, 1'b1);  // abort while idle must not block MTLO
    chk("mtlo_done", {63'b0, bus.done}, 64'h1);
    chk("mtlo_lo", {32'b0, bus.lo}, 64'h22);

    issue(2'b01, 32'd5, 32'd0);
    chk("dz_flag", {63'b0, bus.div_zero}, 64'h1);
    chk("dz_done", {63'b0, bus.done}, 64'h1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("dz_busy_never", 64'(seen), 64'd0);
    chk("dz_hi", {32'b0, bus.hi}, 64'h11);
    chk("dz_lo", {32'b0, bus.lo}, 64'h22);

    issue(2'b00, 32'hFFFFFFFD, 32'd5);
`ifdef MDU_MULT_EN
    wait_done(n);
    chk("mul_lat", 64'(n), 64'd34);
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFF1;
`else
    chk("mul_ill", {63'b0, bus.illegal_op}, 64'h1);
    chk("mul_done", {63'b0, bus.done}, 64'h1);
    exp_hi = 32'h11; exp_lo = 32'h22;
`endif
    chk("mul_hi", {32'b0, bus.hi}, {32'b0, exp_hi});
    chk("mul_lo", {32'b0, bus.lo}, {32'b0, exp_lo});
    @(negedge clk);

    // Abort in RUN cycle 10; an MTHI offered while busy must be ignored.
    issue(2'b01, 32'd50, 32'd3);
    repeat (4) @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 2'b10; bus.a = 32'hDEAD;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_rdy", {63'b0, bus.op_ready}, 64'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_hi", {32'b0, bus.hi}, {32'b0, exp_hi});
    chk("abort_lo", {32'b0, bus.lo}, {32'b0, exp_lo});
    issue(2'b10, 32'h1234, 32'h0);
    chk("mthi2_done", {63'b0, bus.done}, 64'h1);
    chk("mthi2_hi", {32'b0, bus.hi}, 64'h1234);

    // Reset in RUN cycle 20.
    issue(2'b01, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_hi", {32'b0, bus.hi}, 64'h0);
    chk("rst_mid_lo", {32'b0, bus.lo}, 64'h0);
    chk("rst_mid_rdy", {63'b0, bus.op_ready}, 64'h1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("rst_no_done", 64'(seen), 64'd0);

    issue(2'b01, 32'd100, 32'd7);
    wait_done(n);
    chk("div100_7_lat", 64'(n), 64'd34);
    chk("div100_7_lo", {32'b0, bus.lo}, 64'd14);
    chk("div100_7_hi", {32'b0, bus.hi}, 64'd2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
endmodule
